arbitro_mux9: RTL and testbench

Round-robin arbiter and sequencer for the shared 4-input, 16-bit result mux (mux9) in the datapath. Four requesters compete for the mux output; the block grants one at a time, drives the mux `controle` select, and counts word transfers against a downstream `pronto` handshake. Bursts are capped at `MAX_RAJADA` words before the grant rotates. The mux itself stays purely combinational; only this block decides which `entradaN` reaches `saida`.

---
 rtl/arbitro_mux9_if.sv | 35 +++
 rtl/arbitro_mux9.sv | 134 +++++++++++++
 tb/tb_arbitro_mux9.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/arbitro_mux9_if.sv
// arbitro_mux9_if -- handshake bundle between the mux9 arbiter, its four
// requesters and the downstream consumer.
//   req      : per-requester "word present on entrada_i"
//   pronto   : consumer accepts saida this cycle
//   controle : mux select (index of current / last owner)
//   concede  : one-hot grant, zero when idle
//   valido   : a word is present on saida
//   contagem : words moved in the current grant
// modport master : arbiter side; modport slave : requester/consumer side.
interface arbitro_mux9_if;
  logic [3:0] req;
  logic       pronto;
  logic [1:0] controle;
  logic [3:0] concede;
  logic       valido;
  logic [3:0] contagem;

  modport master (
    input  req,
    input  pronto,
    output controle,
    output concede,
    output valido,
    output contagem
  );

  modport slave (
    output req,
    output pronto,
    input  controle,
    input  concede,
    input  valido,
    input  contagem
  );
endinterface

// File: rtl/arbitro_mux9.sv
// arbitro_mux9 -- round-robin arbiter/sequencer for the 4-input result mux.
// Grants one requester at a time, drives the mux select and counts words
// moved against the consumer's pronto handshake, capping each grant at
// MAX_RAJADA words (legal 1..15) before rotating.
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : arbitro_mux9_if.master (req, pronto in; controle, concede,
//           valido, contagem out)
module arbitro_mux9 #(
  parameter int unsigned MAX_RAJADA = 4
) (
  input  logic           clock,
  input  logic           reset,
  arbitro_mux9_if.master bus
);

  typedef enum logic [0:0] {
    OCIOSO    = 1'b0,
    CONCEDIDO = 1'b1
  } estado_t;

  localparam logic [3:0] ULTIMO_C = 4'(MAX_RAJADA - 1);

  estado_t    estado_r, estado_n_s;
  logic [1:0] ptr_r, ptr_n_s;
  logic [3:0] concede_r, concede_n_s;
  logic [1:0] controle_r, controle_n_s;
  logic [3:0] contagem_r, contagem_n_s;

  logic [2:0] busca_livre_s;   // {found, index} searching from ptr
  logic [2:0] busca_troca_s;   // {found, index} excluding the owner
  logic       pedido_dono_s;
  logic       transfer_s;
  logic       limite_s;

  // First set bit of r in the order p, p+1, p+2, p+3 (mod 4).
  function automatic logic [2:0] procura(input logic [3:0] r, input logic [1:0] p);
    logic       found;
    logic [1:0] w;
    logic [1:0] idx;
    found = 1'b0;
    w     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && r[idx]) begin
        found = 1'b1;
        w     = idx;
      end else begin
        found = found;
      end
    end
    return {found, w};
  endfunction

  // Idle search starts at ptr; handover search starts after the owner with
  // the owner masked, which already yields ptr = g+1 ordering.
  assign busca_livre_s = procura(bus.req, ptr_r);
  assign busca_troca_s = procura(bus.req & ~(4'b0001 << controle_r), controle_r + 2'd1);

  assign pedido_dono_s = bus.req[controle_r];
  assign transfer_s    = (estado_r == CONCEDIDO) && pedido_dono_s && bus.pronto;
  assign limite_s      = transfer_s && (contagem_r == ULTIMO_C);

  // Next-state and next-register logic for the grant FSM.
  always_comb begin
    estado_n_s   = estado_r;
    ptr_n_s      = ptr_r;
    concede_n_s  = concede_r;
    controle_n_s = controle_r;
    contagem_n_s = contagem_r;
    case (estado_r)
      OCIOSO: begin
        if (busca_livre_s[2]) begin
          estado_n_s   = CONCEDIDO;
          concede_n_s  = 4'b0001 << busca_livre_s[1:0];
          controle_n_s = busca_livre_s[1:0];
          contagem_n_s = 4'd0;
        end else begin
          estado_n_s = OCIOSO;
        end
      end
      CONCEDIDO: begin
        if (transfer_s && !limite_s) begin
          contagem_n_s = contagem_r + 4'd1;
        end else if (limite_s || !pedido_dono_s) begin
          ptr_n_s = controle_r + 2'd1;
          if (busca_troca_s[2]) begin
            concede_n_s  = 4'b0001 << busca_troca_s[1:0];
            controle_n_s = busca_troca_s[1:0];
            contagem_n_s = 4'd0;
          end else if (limite_s) begin
            // Owner is the only one still asking after a full burst: keep it.
            contagem_n_s = 4'd0;
          end else begin
            estado_n_s   = OCIOSO;
            concede_n_s  = 4'b0000;
            contagem_n_s = 4'd0;
          end
        end else begin
          // Backpressure: owner still asking, consumer not ready.
          contagem_n_s = contagem_r;
        end
      end
      default: begin
        estado_n_s   = OCIOSO;
        concede_n_s  = 4'b0000;
        contagem_n_s = 4'd0;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r   <= OCIOSO;
      ptr_r      <= 2'd0;
      concede_r  <= 4'b0000;
      controle_r <= 2'd0;
      contagem_r <= 4'd0;
    end else begin
      estado_r   <= estado_n_s;
      ptr_r      <= ptr_n_s;
      concede_r  <= concede_n_s;
      controle_r <= controle_n_s;
      contagem_r <= contagem_n_s;
    end
  end

  assign bus.concede  = concede_r;
  assign bus.controle = controle_r;
  assign bus.contagem = contagem_r;
  assign bus.valido   = |(concede_r & bus.req);

endmodule

// File: tb/tb_arbitro_mux9.sv
module tb_arbitro_mux9;
  logic clock;
  logic reset;
  int   passed;
  int   failed;
  int   total;

  arbitro_mux9_if bus ();
  arbitro_mux9_if bus1 ();

  arbitro_mux9 #(.MAX_RAJADA(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  arbitro_mux9 #(.MAX_RAJADA(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [3:0] e;
    passed = 0;
    failed = 0;
    total  = 0;
    reset = 1'b0;
    bus.req = 4'b0000;  bus.pronto = 1'b0;
    bus1.req = 4'b0000; bus1.pronto = 1'b0;
    #3;
    chk("rst_concede",  bus.concede, 4'b0000);
    chk("rst_controle", {2'b00, bus.controle}, 4'd0);
    chk("rst_contagem", bus.contagem, 4'd0);
    chk("rst_valido",   {3'b000, bus.valido}, 4'd0);
    tick(); tick();
    reset = 1'b1;

    // Single requester 2: four transfers then re-grant of 2.
    bus.req = 4'b0100; bus.pronto = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_concede",  bus.concede, 4'b0100);
      chk("t1_controle", {2'b00, bus.controle}, 4'd2);
      chk("t1_contagem", bus.contagem, 4'(k));
      chk("t1_valido",   {3'b000, bus.valido}, 4'd1);
    end
    tick();
    chk("t1_regrant_concede",  bus.concede, 4'b0100);
    chk("t1_regrant_contagem", bus.contagem, 4'd0);
    chk("t1_regrant_ptr",      {2'b00, dut.ptr_r}, 4'd3);
    bus.req = 4'b0000;
    #1;
    chk("t1_valido_drop", {3'b000, bus.valido}, 4'd0);
    tick();
    chk("t1_idle_concede",  bus.concede, 4'b0000);
    chk("t1_idle_controle", {2'b00, bus.controle}, 4'd2);

    // Round-robin with all four requesting from ptr = 0.
    reset = 1'b0; #1; reset = 1'b1;
    bus.req = 4'b1111;
    for (int k = 0; k <= 20; k++) begin
      tick();
      e = 4'b0001 << ((k / 4) % 4);
      chk("rr_concede",  bus.concede, e);
      chk("rr_contagem", bus.contagem, 4'(k % 4));
    end

    // Early drop: owner 1 after two transfers, requester 3 waiting.
    bus.req = 4'b1010;
    tick();
    chk("ed_contagem1", bus.contagem, 4'd1);
    tick();
    chk("ed_contagem2", bus.contagem, 4'd2);
    chk("ed_concede1",  bus.concede, 4'b0010);
    bus.req = 4'b1000;
    tick();
    chk("ed_concede3",  bus.concede, 4'b1000);
    chk("ed_controle3", {2'b00, bus.controle}, 4'd3);
    chk("ed_contagem0", bus.contagem, 4'd0);
    chk("ed_ptr",       {2'b00, dut.ptr_r}, 4'd2);

    // Release to idle, then 1001 grants 0 first.
    bus.req = 4'b0000;
    tick();
    chk("idle_concede",  bus.concede, 4'b0000);
    chk("idle_controle", {2'b00, bus.controle}, 4'd3);
    chk("idle_valido",   {3'b000, bus.valido}, 4'd0);
    bus.req = 4'b1001;
    tick();
    chk("idle_regrant_concede",  bus.concede, 4'b0001);
    chk("idle_regrant_controle", {2'b00, bus.controle}, 4'd0);

    // Backpressure on owner 0.
    bus.pronto = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_concede",  bus.concede, 4'b0001);
      chk("bp_contagem", bus.contagem, 4'd0);
      chk("bp_valido",   {3'b000, bus.valido}, 4'd1);
    end
    bus.pronto = 1'b1;
    tick();
    chk("bp_resume1", bus.contagem, 4'd1);
    tick();
    chk("bp_resume2", bus.contagem, 4'd2);

    // Asynchronous reset mid-burst of owner 2.
    reset = 1'b0; #1; reset = 1'b1;
    bus.req = 4'b0100;
    tick(); tick(); tick();
    chk("ar_pre_concede",  bus.concede, 4'b0100);
    chk("ar_pre_contagem", bus.contagem, 4'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_concede",  bus.concede, 4'b0000);
    chk("ar_controle", {2'b00, bus.controle}, 4'd0);
    chk("ar_contagem", bus.contagem, 4'd0);
    chk("ar_valido",   {3'b000, bus.valido}, 4'd0);
    reset = 1'b1;
    tick();
    chk("ar_after_concede",  bus.concede, 4'b0100);
    chk("ar_after_contagem", bus.contagem, 4'd0);

    // MAX_RAJADA = 1: every transfer rotates between 0 and 1.
    bus1.req = 4'b0011; bus1.pronto = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      e = (k % 2 == 1) ? 4'b0010 : 4'b0001;
      chk("m1_concede",  bus1.concede, e);
      chk("m1_contagem", bus1.contagem, 4'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
